// File: rtl/cr_cddip_support_mc_core.sv
// CDDIP multi-channel support core: per-channel CQE in-flight counters, idle
// detection with settle delay, sticky maskable interrupts and an OSF halt FSM.

module cr_cddip_support_mc_ch #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cqe_rx,
    input  logic             cqe_exit,
    input  logic             err_clr,
    output logic [CNT_W-1:0] cnt,
    output logic             err
);
    logic up, dn, ovf, unf;

    assign up  = cqe_rx & ~cqe_exit;
    assign dn  = cqe_exit & ~cqe_rx;
    assign ovf = up & (cnt == '1);
    assign unf = dn & (cnt == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
            err <= 1'b0;
        end else begin
            if (up && !ovf)
                cnt <= cnt + 1'b1;
            else if (dn && !unf)
                cnt <= cnt - 1'b1;
            // A new over/underflow beats a same-cycle clear.
            if (ovf || unf)
                err <= 1'b1;
            else if (err_clr)
                err <= 1'b0;
        end
    end
endmodule

module cr_cddip_support_mc_core #(
    parameter int N_CH            = 4,
    parameter int CNT_W           = 8,
    parameter int N_SRC           = 8,
    parameter int IDLE_DLY        = 4,
    parameter int HALT_ON_CNT_ERR = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [N_CH-1:0]       cqe_rx,
    input  logic [N_CH-1:0]       cqe_exit,
    input  logic [N_SRC-1:0]      int_src,
    input  logic [N_SRC-1:0]      int_mask,
    input  logic [N_SRC-1:0]      int_halt_en,
    input  logic [N_SRC-1:0]      int_clr,
    input  logic                  cnt_err_clr,
    input  logic                  halt_release,
    output logic [N_SRC-1:0]      int_status,
    output logic [N_CH-1:0]       cnt_err,
    output logic [N_CH*CNT_W-1:0] inflight_cnt,
    output logic                  cddip_int,
    output logic                  cddip_idle,
    output logic                  sup_osf_halt
);
    typedef enum logic {ST_RUN, ST_HALT} state_t;

    localparam logic [7:0] DLY = 8'(IDLE_DLY);

    state_t     state, state_nxt;
    logic       quiet, halt_cond, idle_nxt;
    logic [7:0] idle_tmr;
    logic [8:0] tmr_inc;

    for (genvar c = 0; c < N_CH; c++) begin : g_ch
        cr_cddip_support_mc_ch #(.CNT_W(CNT_W)) u_ch (
            .clk      (clk),
            .rst_n    (rst_n),
            .cqe_rx   (cqe_rx[c]),
            .cqe_exit (cqe_exit[c]),
            .err_clr  (cnt_err_clr),
            .cnt      (inflight_cnt[c*CNT_W +: CNT_W]),
            .err      (cnt_err[c])
        );
    end

    assign quiet   = (inflight_cnt == '0) && (cqe_rx == '0);
    assign tmr_inc = {1'b0, idle_tmr} + 9'd1;
    // Idle stays up through quiet cycles and only rises once the timer lands on DLY.
    assign idle_nxt = quiet & (cddip_idle | (tmr_inc >= {1'b0, DLY}));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idle_tmr   <= '0;
            cddip_idle <= 1'b1;
        end else begin
            cddip_idle <= idle_nxt;
            if (!quiet)
                idle_tmr <= '0;
            else if (idle_tmr != DLY)
                idle_tmr <= tmr_inc[7:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            int_status <= '0;
            cddip_int  <= 1'b0;
        end else begin
            int_status <= int_src | (int_status & ~int_clr);
            cddip_int  <= (|(int_status & ~int_mask)) | (|cnt_err);
        end
    end

    assign halt_cond = (|(int_status & int_halt_en)) |
                       ((HALT_ON_CNT_ERR != 0) & (|cnt_err));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_RUN;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_RUN:  if (halt_cond) state_nxt = ST_HALT;
            ST_HALT: if (halt_release && !halt_cond) state_nxt = ST_RUN;
            default: state_nxt = ST_RUN;
        endcase
    end

    assign sup_osf_halt = (state == ST_HALT);
endmodule

// File: doc/cr_cddip_support_mc_core.md
Name: cr_cddip_support_mc_core

Overview:
Multi-channel successor to the CDDIP support core. It tracks in-flight command queue entries for N_CH independent ingress/egress channel pairs and derives engine idle with a programmable settle delay. It also aggregates N_SRC interrupt sources into sticky, maskable status and drives a halt state machine toward the output frame logic. The block sits between the ISF/OSF channel pulses and the support register file.

Parameters:
N_CH, 4, number of CQE channels (1..16)
CNT_W, 8, width of each per-channel in-flight counter
N_SRC, 8, number of interrupt sources
IDLE_DLY, 4, cycles all channels must be quiet before idle asserts (0..255)
HALT_ON_CNT_ERR, 1, if 1 a counter error forces halt

Ports:
clk  in  1  core clock
rst_n  in  1  asynchronous active-low reset
cqe_rx  in  N_CH  per-channel CQE received pulse (ISF)
cqe_exit  in  N_CH  per-channel CQE exit pulse (OSF)
int_src  in  N_SRC  level/pulse interrupt sources
int_mask  in  N_SRC  1 = source masked from cddip_int
int_halt_en  in  N_SRC  1 = source status causes halt
int_clr  in  N_SRC  write-1-to-clear pulse for int_status
cnt_err_clr  in  1  pulse, clears cnt_err
halt_release  in  1  pulse, requests exit from HALT
int_status  out  N_SRC  sticky interrupt status
cnt_err  out  N_CH  sticky per-channel over/underflow
inflight_cnt  out  N_CH*CNT_W  packed counters, channel 0 in LSBs
cddip_int  out  1  aggregated interrupt
cddip_idle  out  1  engine idle
sup_osf_halt  out  1  halt request to OSF

Behaviour:
- Async reset: counters 0, int_status 0, cnt_err 0, cddip_int 0, sup_osf_halt 0, cddip_idle 1, idle timer 0, FSM RUN. All outputs are registered.
- Counter per channel, each cycle:
  - rx&exit: hold.
  - rx only: +1; at all-ones, hold and set cnt_err[ch].
  - exit only: -1; at 0, hold 0 and set cnt_err[ch].
  - Effect is visible on inflight_cnt the next cycle.
- cnt_err: set wins over a simultaneous cnt_err_clr.
- Quiet condition: all counters 0 and no cqe_rx asserted this cycle.
- Idle timer counts quiet cycles and saturates at IDLE_DLY.
  - Any non-quiet cycle resets the timer to 0 and deasserts cddip_idle on the next edge.
  - cddip_idle reasserts on the edge where the timer reaches IDLE_DLY.
  - IDLE_DLY=0: cddip_idle = registered quiet.
- int_status[i] next = int_src[i] | (int_status[i] & ~int_clr[i]). A simultaneous source and clear leaves the bit set.
- cddip_int next = |(int_status & ~int_mask) | (|cnt_err). Latency from int_src to cddip_int is 2 cycles; a mask change takes effect in 1 cycle.
- halt_cond = |(int_status & int_halt_en) | (HALT_ON_CNT_ERR & |cnt_err). The mask does not affect halt.
- FSM:
  - RUN: sup_osf_halt=0. Go to HALT when halt_cond=1 (halt asserts 2 cycles after int_src).
  - HALT: sup_osf_halt=1. Go to RUN only on halt_release=1 with halt_cond=0 in the same cycle; otherwise the release is ignored (not queued).
  - Counters and idle keep operating in HALT.
- Reset mid-operation returns every register to its reset value immediately; no pulses are remembered.
- Channels are independent; simultaneous events on different channels do not interact.

Test Plan:
1. Reset release, no stimulus -> cddip_idle=1, all outputs 0, inflight_cnt=0.
2. ch2: 3 cqe_rx pulses then 3 cqe_exit, IDLE_DLY=4 -> inflight_cnt ch2 goes 1,2,3,2,1,0; cddip_idle drops the cycle after the first rx and rises 4 cycles after the count returns to 0.
3. ch0: rx&exit same cycle at count 5 -> stays 5. Then exit at count 0 -> stays 0, cnt_err[0]=1, cddip_int=1 next cycle, sup_osf_halt=1.
4. CNT_W=8, ch1: 256 rx pulses -> count holds 255, cnt_err[1]=1. cnt_err_clr -> clears; no halt release without that clear.
5. int_src[3] 1-cycle pulse, mask[3]=0, halt_en[3]=1 -> int_status[3]=1 at t+1, cddip_int=1 and halt=1 at t+2. halt_release before int_clr[3] -> halt stays 1. int_clr[3] then halt_release -> halt=0.
6. int_src[5] held high with int_clr[5] pulsed -> int_status[5] stays 1. mask[5]=1 -> cddip_int=0 one cycle later. Assert rst_n=0 mid-HALT -> all outputs return to reset values, cddip_idle=1.
